imm_encode: RTL and testbench

- Dual-lane immediate encoder: inverse of the decode-stage immediate extender.
- Takes a pair of 32-bit operand values, each with a requested ImmSrc format, and produces the 24-bit instruction immediate field plus a fit flag per lane.
- Sits in the instruction-generation / self-check path of the dual-issue core. Two-stage valid/ready pipeline; both lanes always move together as one issue pair.

---
 rtl/imm_encode.sv | 166 ++++++++++++++++
 tb/tb_imm_encode.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encode.sv
// imm_encode: dual-lane immediate encoder, the inverse of the decode-stage
// immediate extender. Each lane turns an operand value plus a requested
// ImmSrc format into the 24-bit instruction immediate field and a flag that
// says whether the value is exactly representable in that format.
// Both lanes travel together through a two-stage valid/ready pipeline.
// Optional feature: define IMM_ENCODE_MISFIT_CNT_EN to add the saturating
// misfit counter output o_MisfitCnt.
`ifndef D_WIDTH
`define D_WIDTH 32
`endif

module imm_encode #(
   parameter int D_WIDTH = `D_WIDTH
`ifdef IMM_ENCODE_MISFIT_CNT_EN
   ,
   parameter int CNT_W = 16
`endif
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_Valid,
   output logic               o_Ready,
   input  logic [D_WIDTH-1:0] i_Value1,
   input  logic [D_WIDTH-1:0] i_Value2,
   input  logic [1:0]         i_ImmSrc1,
   input  logic [1:0]         i_ImmSrc2,
   input  logic [1:0]         i_LaneEn,
   output logic               o_Valid,
   input  logic               i_Ready,
   output logic [23:0]        o_Imm24_1,
   output logic [23:0]        o_Imm24_2,
   output logic [1:0]         o_ImmSrc1,
   output logic [1:0]         o_ImmSrc2,
   output logic [1:0]         o_Fit
`ifdef IMM_ENCODE_MISFIT_CNT_EN
   ,
   output logic [CNT_W-1:0]   o_MisfitCnt
`endif
);

   typedef struct packed {
      logic        fit;
      logic [1:0]  src;
      logic [23:0] imm;
   } lane_res_t;

   // A value fits when re-extending the truncated field gives the value back,
   // which is exactly the round-trip property the decoder relies on.
   function automatic lane_res_t encode_lane(input logic [D_WIDTH-1:0] v,
                                             input logic [1:0]         src,
                                             input logic               en);
      lane_res_t r;
      r.fit = 1'b1;
      r.src = 2'b00;
      r.imm = '0;
      if (en) begin
         r.src = src;
         case (src)
            2'b00: begin
               r.imm = {16'h0000, v[7:0]};
               r.fit = (v == {{(D_WIDTH-8){v[7]}}, v[7:0]});
            end
            2'b01: begin
               r.imm = {12'h000, v[11:0]};
               r.fit = (v == {{(D_WIDTH-12){1'b0}}, v[11:0]});
            end
            2'b10: begin
               r.imm = v[23:0];
               r.fit = (v == {{(D_WIDTH-24){v[23]}}, v[23:0]});
            end
            default: begin
               r.imm = '0;
               r.fit = 1'b0;
            end
         endcase
      end
      return r;
   endfunction

   logic               a_valid;
   logic [D_WIDTH-1:0] a_value1;
   logic [D_WIDTH-1:0] a_value2;
   logic [1:0]         a_src1;
   logic [1:0]         a_src2;
   logic [1:0]         a_lane_en;
   logic               a_load;
   logic               b_load;
   lane_res_t          lane1_res;
   lane_res_t          lane2_res;

   // Stage B frees up when it is empty or its pair is being taken; stage A
   // can take a new pair when it is empty or its pair is moving into B.
   always_comb begin
      b_load  = ~o_Valid | i_Ready;
      a_load  = ~a_valid | b_load;
      o_Ready = a_load;
   end

   // Stage A: capture the raw issue pair on the input handshake.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         a_valid   <= 1'b0;
         a_value1  <= '0;
         a_value2  <= '0;
         a_src1    <= 2'b00;
         a_src2    <= 2'b00;
         a_lane_en <= 2'b00;
      end else if (a_load) begin
         a_valid   <= i_Valid;
         a_value1  <= i_Value1;
         a_value2  <= i_Value2;
         a_src1    <= i_ImmSrc1;
         a_src2    <= i_ImmSrc2;
         a_lane_en <= i_LaneEn;
      end
   end

   // Encode both lanes from the stage A contents.
   always_comb begin
      lane1_res = encode_lane(a_value1, a_src1, a_lane_en[0]);
      lane2_res = encode_lane(a_value2, a_src2, a_lane_en[1]);
   end

   // Stage B: hold the encoded pair until the consumer takes it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_Valid   <= 1'b0;
         o_Imm24_1 <= '0;
         o_Imm24_2 <= '0;
         o_ImmSrc1 <= 2'b00;
         o_ImmSrc2 <= 2'b00;
         o_Fit     <= 2'b00;
      end else if (b_load) begin
         o_Valid <= a_valid;
         if (a_valid) begin
            o_Imm24_1 <= lane1_res.imm;
            o_Imm24_2 <= lane2_res.imm;
            o_ImmSrc1 <= lane1_res.src;
            o_ImmSrc2 <= lane2_res.src;
            o_Fit     <= {lane2_res.fit, lane1_res.fit};
         end
      end
   end

`ifdef IMM_ENCODE_MISFIT_CNT_EN
   logic [1:0]     misfit_inc;
   logic [CNT_W:0] cnt_sum;

   // Disabled lanes report fit=1, so counting zero fit bits counts only
   // enabled lanes that did not fit. The extra sum bit detects saturation.
   always_comb begin
      misfit_inc = {1'b0, ~o_Fit[0]} + {1'b0, ~o_Fit[1]};
      cnt_sum    = {1'b0, o_MisfitCnt} + {{(CNT_W-1){1'b0}}, misfit_inc};
   end

   // Accumulate misfits on each delivered pair, sticking at all-ones.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_MisfitCnt <= '0;
      end else if (o_Valid && i_Ready) begin
         o_MisfitCnt <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
      end
   end
`endif

endmodule

// File: tb/tb_imm_encode.sv
// tb_imm_encode: randomized and directed bench for imm_encode. A queue-based
// reference model predicts every delivered pair from the format rules using
// plain signed-range arithmetic; one monitor compares the DUT against it on
// every cycle.
`timescale 1ns/1ps

module tb_imm_encode;

   localparam int CNT_W   = 16;
   localparam int CNT_CAP = (1 << CNT_W) - 1;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_Valid;
   logic        o_Ready;
   logic [31:0] i_Value1;
   logic [31:0] i_Value2;
   logic [1:0]  i_ImmSrc1;
   logic [1:0]  i_ImmSrc2;
   logic [1:0]  i_LaneEn;
   logic        o_Valid;
   logic        i_Ready;
   logic [23:0] o_Imm24_1;
   logic [23:0] o_Imm24_2;
   logic [1:0]  o_ImmSrc1;
   logic [1:0]  o_ImmSrc2;
   logic [1:0]  o_Fit;
`ifdef IMM_ENCODE_MISFIT_CNT_EN
   logic [CNT_W-1:0] o_MisfitCnt;
`endif

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int model_cnt = 0;

   typedef struct {
      logic [23:0] imm1;
      logic [23:0] imm2;
      logic [1:0]  src1;
      logic [1:0]  src2;
      logic [1:0]  fit;
      int          born;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   logic mon_exp_valid;

   imm_encode dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_Valid(i_Valid),
      .o_Ready(o_Ready),
      .i_Value1(i_Value1),
      .i_Value2(i_Value2),
      .i_ImmSrc1(i_ImmSrc1),
      .i_ImmSrc2(i_ImmSrc2),
      .i_LaneEn(i_LaneEn),
      .o_Valid(o_Valid),
      .i_Ready(i_Ready),
      .o_Imm24_1(o_Imm24_1),
      .o_Imm24_2(o_Imm24_2),
      .o_ImmSrc1(o_ImmSrc1),
      .o_ImmSrc2(o_ImmSrc2),
      .o_Fit(o_Fit)
`ifdef IMM_ENCODE_MISFIT_CNT_EN
      ,
      .o_MisfitCnt(o_MisfitCnt)
`endif
   );

   always #5 i_clk = ~i_clk;

   // Reference lane: fit is a signed/unsigned range test on the value,
   // the field is the value modulo the field size.
   function automatic void model_lane(input logic [31:0] v, input logic [1:0] src, input logic en,
                                      output logic [23:0] imm, output logic [1:0] src_o,
                                      output logic fit);
      longint s;
      s     = $signed(v);
      imm   = '0;
      src_o = 2'b00;
      fit   = 1'b1;
      if (en) begin
         src_o = src;
         case (src)
            2'd0: begin fit = (s >= -128 && s <= 127); imm = 24'(v % 32'd256); end
            2'd1: begin fit = (v < 32'd4096); imm = 24'(v % 32'd4096); end
            2'd2: begin fit = (s >= -8388608 && s <= 8388607); imm = 24'(v % 32'h0100_0000); end
            default: begin fit = 1'b0; imm = '0; end
         endcase
      end
   endfunction

   function automatic exp_t modelPair(input int born);
      exp_t e;
      logic f1, f2;
      model_lane(i_Value1, i_ImmSrc1, i_LaneEn[0], e.imm1, e.src1, f1);
      model_lane(i_Value2, i_ImmSrc2, i_LaneEn[1], e.imm2, e.src2, f2);
      e.fit  = {f2, f1};
      e.born = born;
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: sample mid-cycle, compare against the model, then account for
   // the handshakes that the coming rising edge will perform.
   always @(negedge i_clk) begin
      cyc++;
      if (i_rst) begin
         exp_q.delete();
         model_cnt = 0;
         checkOutput("reset_valid", {63'd0, o_Valid}, 64'd0);
         checkOutput("reset_data", {10'd0, o_Imm24_1, o_Imm24_2, o_ImmSrc1, o_ImmSrc2, o_Fit}, 64'd0);
`ifdef IMM_ENCODE_MISFIT_CNT_EN
         checkOutput("reset_cnt", 64'(o_MisfitCnt), 64'd0);
`endif
      end else begin
         checkOutput("o_Ready", {63'd0, o_Ready}, {63'd0, (exp_q.size() < 2) || i_Ready});
         mon_exp_valid = 1'b0;
         if (exp_q.size() > 0) mon_exp_valid = (cyc - exp_q[0].born) >= 2;
         checkOutput("o_Valid", {63'd0, o_Valid}, {63'd0, mon_exp_valid});
`ifdef IMM_ENCODE_MISFIT_CNT_EN
         checkOutput("misfit_cnt", 64'(o_MisfitCnt), 64'(model_cnt));
`endif
         if (o_Valid && exp_q.size() > 0) begin
            mon_e = exp_q[0];
            checkOutput("pair", {10'd0, o_Imm24_1, o_Imm24_2, o_ImmSrc1, o_ImmSrc2, o_Fit},
                        {10'd0, mon_e.imm1, mon_e.imm2, mon_e.src1, mon_e.src2, mon_e.fit});
            if (i_Ready) begin
               void'(exp_q.pop_front());
               model_cnt = model_cnt + (mon_e.fit[0] ? 0 : 1) + (mon_e.fit[1] ? 0 : 1);
               if (model_cnt > CNT_CAP) model_cnt = CNT_CAP;
            end
         end
         if (i_Valid && o_Ready) exp_q.push_back(modelPair(cyc));
      end
   end

   task automatic nextCycle();
      @(posedge i_clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] v1, input logic [1:0] s1,
                                input logic [31:0] v2, input logic [1:0] s2, input logic [1:0] en);
      i_Value1  = v1;
      i_ImmSrc1 = s1;
      i_Value2  = v2;
      i_ImmSrc2 = s2;
      i_LaneEn  = en;
      i_Valid   = 1'b1;
   endtask

   task automatic doReset();
      i_Valid = 1'b0;
      i_Ready = 1'b1;
      i_rst   = 1'b1;
      repeat (2) nextCycle();
      i_rst = 1'b0;
      nextCycle();
   endtask

   task automatic drain();
      int t;
      i_Valid = 1'b0;
      i_Ready = 1'b1;
      t = 0;
      while (exp_q.size() > 0 && t < 20) begin
         nextCycle();
         t++;
      end
      checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   // One pair through an idle pipeline with the consumer always ready.
   task automatic runSingle(input string name, input logic [31:0] v1, input logic [1:0] s1,
                            input logic [31:0] v2, input logic [1:0] s2, input logic [1:0] en,
                            input logic [23:0] e_imm1, input logic [23:0] e_imm2,
                            input logic [1:0] e_src1, input logic [1:0] e_src2,
                            input logic [1:0] e_fit);
      int n;
      i_Ready = 1'b1;
      applyStimulus(v1, s1, v2, s2, en);
      nextCycle();
      i_Valid = 1'b0;
      n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while (!o_Valid && n < 8);
      checkOutput({name, "_latency"}, 64'(n), 64'd2);
      checkOutput({name, "_imm1"}, 64'(o_Imm24_1), 64'(e_imm1));
      checkOutput({name, "_imm2"}, 64'(o_Imm24_2), 64'(e_imm2));
      checkOutput({name, "_src"}, {60'd0, o_ImmSrc2, o_ImmSrc1}, {60'd0, e_src2, e_src1});
      checkOutput({name, "_fit"}, 64'(o_Fit), 64'(e_fit));
      nextCycle();
   endtask

   // Hand-computed values that pin the reference model itself.
   task automatic modelSelfCheck();
      logic [23:0] imm;
      logic [1:0]  s;
      logic        f;
      model_lane(32'hFFFF_FF80, 2'd0, 1'b1, imm, s, f);
      checkOutput("model_dpi_neg", {39'd0, imm, f}, {39'd0, 24'h000080, 1'b1});
      model_lane(32'h0000_1000, 2'd1, 1'b1, imm, s, f);
      checkOutput("model_dti_over", {39'd0, imm, f}, {39'd0, 24'h000000, 1'b0});
      model_lane(32'hFF80_0000, 2'd2, 1'b1, imm, s, f);
      checkOutput("model_br_min", {39'd0, imm, f}, {39'd0, 24'h800000, 1'b1});
      model_lane(32'h0080_0000, 2'd2, 1'b1, imm, s, f);
      checkOutput("model_br_over", {39'd0, imm, f}, {39'd0, 24'h800000, 1'b0});
   endtask

   function automatic logic [31:0] randVal();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 4))
         0: return r;
         1: return {{24{r[7]}}, r[7:0]};
         2: return {20'h00000, r[11:0]};
         3: return {{8{r[23]}}, r[23:0]};
         default: return {{8{r[23]}}, r[23:0]} ^ (32'd1 << $urandom_range(23, 31));
      endcase
   endfunction

   task automatic randomStream(input int cycles);
      for (int k = 0; k < cycles; k++) begin
         if ($urandom_range(0, 3) != 0)
            applyStimulus(randVal(), 2'($urandom_range(0, 3)), randVal(), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 3)));
         else
            i_Valid = 1'b0;
         i_Ready = ($urandom_range(0, 3) != 0);
         nextCycle();
      end
      drain();
   endtask

   // Five pairs offered back to back while the consumer stalls for 4 cycles.
   task automatic backpressure();
      int  sent;
      int  t;
      logic acc;
      sent    = 0;
      t       = 0;
      i_Valid = 1'b0;
      i_Ready = 1'b0;
      while (sent < 5 && t < 50) begin
         if (!i_Valid)
            applyStimulus(randVal(), 2'($urandom_range(0, 2)), randVal(), 2'($urandom_range(0, 2)), 2'b11);
         @(negedge i_clk);
         acc = o_Ready;
         if (t == 3) begin
            checkOutput("bp_accepted", 64'(sent), 64'd2);
            checkOutput("bp_ready_low", {63'd0, o_Ready}, 64'd0);
         end
         @(posedge i_clk);
         #1;
         if (acc) begin
            sent++;
            i_Valid = 1'b0;
         end
         t++;
         i_Ready = (t >= 4);
      end
      checkOutput("bp_sent", 64'(sent), 64'd5);
      drain();
   endtask

   task automatic resetInFlight();
      i_Ready = 1'b0;
      applyStimulus(32'h0000_0011, 2'd0, 32'h0000_0022, 2'd1, 2'b11);
      nextCycle();
      applyStimulus(32'h0000_0033, 2'd0, 32'h0000_0044, 2'd1, 2'b11);
      nextCycle();
      i_Valid = 1'b0;
      #2;
      checkOutput("inflight_valid", {63'd0, o_Valid}, 64'd1);
      i_rst = 1'b1;
      #1;
      checkOutput("async_clear_valid", {63'd0, o_Valid}, 64'd0);
      repeat (2) nextCycle();
      i_rst   = 1'b0;
      i_Ready = 1'b1;
      repeat (6) nextCycle();
      checkOutput("no_stale_pair", {63'd0, o_Valid}, 64'd0);
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      i_rst     = 1'b1;
      i_Valid   = 1'b0;
      i_Ready   = 1'b1;
      i_Value1  = '0;
      i_Value2  = '0;
      i_ImmSrc1 = 2'b00;
      i_ImmSrc2 = 2'b00;
      i_LaneEn  = 2'b11;

      modelSelfCheck();
      doReset();
      checkOutput("ready_after_reset", {63'd0, o_Ready}, 64'd1);

      runSingle("single", 32'hFFFF_FF80, 2'd0, 32'h0000_0ABC, 2'd1, 2'b11,
                24'h000080, 24'h000ABC, 2'd0, 2'd1, 2'b11);
      runSingle("misfit", 32'h0000_0080, 2'd0, 32'h0000_1000, 2'd1, 2'b11,
                24'h000080, 24'h000000, 2'd0, 2'd1, 2'b00);
`ifdef IMM_ENCODE_MISFIT_CNT_EN
      checkOutput("cnt_after_misfit", 64'(o_MisfitCnt), 64'd2);
`endif
      runSingle("branch", 32'hFF80_0000, 2'd2, 32'h0080_0000, 2'd2, 2'b11,
                24'h800000, 24'h800000, 2'd2, 2'd2, 2'b01);
`ifdef IMM_ENCODE_MISFIT_CNT_EN
      checkOutput("cnt_after_branch", 64'(o_MisfitCnt), 64'd3);
`endif
      runSingle("lane_dis", $urandom, 2'd3, $urandom, 2'($urandom_range(0, 3)), 2'b01,
                24'h000000, 24'h000000, 2'd3, 2'd0, 2'b10);
`ifdef IMM_ENCODE_MISFIT_CNT_EN
      checkOutput("cnt_after_lane_dis", 64'(o_MisfitCnt), 64'd4);
`endif

      backpressure();
      randomStream(400);
      resetInFlight();
      randomStream(200);

`ifdef IMM_ENCODE_MISFIT_CNT_EN
      doReset();
      applyStimulus(32'h0000_0080, 2'd0, 32'h0000_1000, 2'd1, 2'b11);
      repeat (32767) nextCycle();
      drain();
      checkOutput("cnt_preload", 64'(o_MisfitCnt), 64'h0000_FFFE);
      runSingle("sat1", 32'h0000_0080, 2'd0, 32'h0000_1000, 2'd1, 2'b11,
                24'h000080, 24'h000000, 2'd0, 2'd1, 2'b00);
      checkOutput("cnt_saturate", 64'(o_MisfitCnt), 64'h0000_FFFF);
      runSingle("sat2", 32'h0000_0080, 2'd0, 32'h0000_1000, 2'd1, 2'b11,
                24'h000080, 24'h000000, 2'd0, 2'd1, 2'b00);
      checkOutput("cnt_hold", 64'(o_MisfitCnt), 64'h0000_FFFF);
`endif

      drain();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
